// File: rtl/bram_reader_pkg.sv
// Shared types and constants for the BRAM burst reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bram_reader_pkg;

    // Address bits below this index select a word inside one RAM bank;
    // bits above select the bank whose output register drives read data.
    localparam int BANK_BITS  = 10;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/bram_burst_reader_if.sv
// Command, RAM-port and output-stream signals of the BRAM burst reader.
// Latency: n/a (wiring only).
// Backpressure: out_ready stalls the stream; cmd_ready is high only when idle.
// master = the reader itself, slave = command source / RAM / stream consumer.
interface bram_burst_reader_if
    import bram_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 12
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [LEN_WIDTH-1:0]    cmd_len;

    logic                    mem_clken;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [WORD_BYTES-1:0]   mem_we;
    logic [8*WORD_BYTES-1:0] mem_data_in;
    logic [8*WORD_BYTES-1:0] mem_data_out;

    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_data;
    logic                    out_last;

    logic                    busy;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, mem_data_out, out_ready,
        output cmd_ready, mem_clken, mem_addr, mem_we, mem_data_in,
               out_valid, out_data, out_last, busy
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, mem_data_out, out_ready,
        input  cmd_ready, mem_clken, mem_addr, mem_we, mem_data_in,
               out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/bram_reader_fifo.sv
// Synchronous output buffer of {last, data} entries with occupancy count and flush.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: none internally; the caller's credit check guarantees no overflow.
// Ports: clk/reset, push + push_dat, pop, flush (clears all entries), head, count.
module bram_reader_fifo
    import bram_reader_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  fifo_entry_t    push_dat,
    input  logic           pop,
    input  logic           flush,
    output fifo_entry_t    head,
    output logic [CW-1:0]  count
);
    localparam int PW = $clog2(DEPTH);

    fifo_entry_t   store [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    assign head = store[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) store[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/bram_burst_reader.sv
// Burst read initiator for one BRAM port: sequential word reads -> valid/ready stream with last.
// Latency: first word valid 2 cycles after command acceptance, then 1 word/cycle (+1 bubble per bank crossing).
// Backpressure: reads are issued only while buffer credit remains; out_ready low stalls issue, never drops data.
// Ports: clk, reset (async, active-high), bus (master modport: cmd_*, mem_*, out_*, busy).
// Build option BRAM_READER_ABORT_EN adds input abort: flushes the burst and returns to idle next cycle.
module bram_burst_reader
    import bram_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
`ifdef BRAM_READER_ABORT_EN
    input  logic abort,
`endif
    bram_burst_reader_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;        // next address to read
    logic [ADDR_WIDTH-1:0] last_addr;   // address of the most recent read; drives mem_addr between issues
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  in_flight;   // a read was issued last cycle; its data is captured this cycle
    logic                  in_flight_last;

    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         count_after_pop;
    fifo_entry_t           head;
    fifo_entry_t           push_dat;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic                  credit_ok;
    logic                  bubble;
    logic                  abort_req;
    logic                  drain_done;

`ifdef BRAM_READER_ABORT_EN
    assign abort_req = abort && (state != S_IDLE);
`else
    assign abort_req = 1'b0;
`endif

    assign bus.out_valid  = (fifo_count != '0);
    assign pop            = bus.out_valid && bus.out_ready;
    assign count_after_pop = fifo_count - CW'(pop);

    // Every issued read must have a guaranteed slot: words already buffered,
    // the one landing this cycle and the new one must all fit.
    assign credit_ok = ({1'b0, count_after_pop} + (CW + 1)'(in_flight) + (CW + 1)'(1)) <= DEPTH_C;

    // The RAM's data mux follows the live address bank, so a read into a new
    // bank cannot be driven while the previous bank's word is being captured.
    assign bubble = in_flight &&
                    (addr[ADDR_WIDTH-1:BANK_BITS] != last_addr[ADDR_WIDTH-1:BANK_BITS]);

    assign issue      = (state == S_RUN) && credit_ok && !bubble && !abort_req;
    assign push       = in_flight && !abort_req;
    assign drain_done = (state == S_DRAIN) && !in_flight && (count_after_pop == '0);

    assign push_dat = '{last: in_flight_last, data: bus.mem_data_out};

    assign bus.mem_clken   = issue;
    assign bus.mem_addr    = issue ? addr : last_addr;
    assign bus.mem_we      = '0;
    assign bus.mem_data_in = '0;
    assign bus.cmd_ready   = (state == S_IDLE);
    assign bus.busy        = (state != S_IDLE);
    // Gated so stale buffer contents never show on the bus while empty.
    assign bus.out_data    = bus.out_valid ? head.data : 32'h0;
    assign bus.out_last    = bus.out_valid && head.last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            addr           <= '0;
            last_addr      <= '0;
            remaining      <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
        end else begin
            in_flight      <= issue;
            in_flight_last <= issue && (remaining == LEN_WIDTH'(1));
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        addr      <= bus.cmd_addr;
                        remaining <= bus.cmd_len;
                        if (bus.cmd_len != '0) state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        last_addr <= addr;
                        addr      <= addr + ADDR_WIDTH'(1);
                        remaining <= remaining - LEN_WIDTH'(1);
                    end
                    if (abort_req)
                        state <= S_IDLE;
                    else if (issue && (remaining == LEN_WIDTH'(1)))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (abort_req || drain_done) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    bram_reader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (abort_req),
        .head     (head),
        .count    (fifo_count)
    );
endmodule

// File: tb/tb_bram_burst_reader.sv
// Directed bench for bram_burst_reader with a banked BRAM read-port model.
// Latency: n/a.
// Backpressure: out_ready driven high or 1-of-3 cycles per step.
module tb_bram_burst_reader;
    logic clk = 1'b0;
    logic reset = 1'b1;
`ifdef BRAM_READER_ABORT_EN
    logic abort = 1'b0;
`endif
    always #5 clk = ~clk;

    bram_burst_reader_if #(.ADDR_WIDTH(12), .LEN_WIDTH(12)) bus ();

    bram_burst_reader #(.ADDR_WIDTH(12), .LEN_WIDTH(12), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef BRAM_READER_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    // RAM model: each 1K-word bank has its own output register; the output
    // mux follows the currently driven address bank. Word at a = BEEF0_<a>.
    logic [31:0] bank_q [4];
    always @(posedge clk) begin
        if (bus.mem_clken) bank_q[bus.mem_addr[11:10]] <= {16'hBEEF, 4'h0, bus.mem_addr};
    end
    assign bus.mem_data_out = bank_q[bus.mem_addr[11:10]];

    int total = 0;
    int bad = 0;

    logic [31:0] got_data [$];
    logic        got_last [$];
    logic [11:0] iss_addr [$];
    int          iss_cyc  [$];
    logic [11:0] exp_q    [$];
    int          max_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [11:0] a, input logic [11:0] l);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        @(negedge clk);
        chk("cmd_accept", bus.cmd_ready, 1);
        next_cycle();
        bus.cmd_valid = 1'b0;
    endtask

    // mode 0: out_ready always high; mode 1: high on every third cycle.
    task automatic collect(input int mode, input int budget);
        int issued;
        int popped;
        bit done;
        got_data.delete(); got_last.delete(); iss_addr.delete(); iss_cyc.delete();
        issued = 0; popped = 0; max_out = 0; done = 0;
        for (int cyc = 1; cyc <= budget && !done; cyc++) begin
            bus.out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            @(negedge clk);
            if (bus.mem_clken) begin
                iss_addr.push_back(bus.mem_addr);
                iss_cyc.push_back(cyc);
                issued++;
            end
            if (bus.out_valid && bus.out_ready) begin
                got_data.push_back(bus.out_data);
                got_last.push_back(bus.out_last);
                popped++;
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (!bus.busy && !bus.out_valid) done = 1;
            next_cycle();
        end
        chk("collect_timeout", done, 1);
        bus.out_ready = 1'b1;
    endtask

    task automatic check_burst(input string tag);
        chk({tag, "_issues"}, iss_addr.size(), exp_q.size());
        chk({tag, "_words"}, got_data.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk({tag, "_addr"}, iss_addr[i], exp_q[i]);
            chk({tag, "_data"}, got_data[i], {16'hBEEF, 4'h0, exp_q[i]});
            chk({tag, "_last"}, got_last[i], (i == exp_q.size() - 1) ? 1 : 0);
        end
    endtask

    initial begin
        for (int b = 0; b < 4; b++) bank_q[b] = 32'h0BAD0BAD;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_clken", bus.mem_clken, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_wdata", bus.mem_data_in, 0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Burst 0x010 x4, cycle-exact
        start_cmd(12'h010, 12'd4);
        @(negedge clk);
        chk("b1_c1_clken", bus.mem_clken, 1);
        chk("b1_c1_addr", bus.mem_addr, 12'h010);
        chk("b1_c1_busy", bus.busy, 1);
        chk("b1_c1_cmd_ready", bus.cmd_ready, 0);
        chk("b1_c1_valid", bus.out_valid, 0);
        next_cycle(); @(negedge clk);
        chk("b1_c2_clken", bus.mem_clken, 1);
        chk("b1_c2_addr", bus.mem_addr, 12'h011);
        chk("b1_c2_valid", bus.out_valid, 0);
        next_cycle(); @(negedge clk);
        chk("b1_c3_valid", bus.out_valid, 1);
        chk("b1_c3_data", bus.out_data, 32'hBEEF0010);
        chk("b1_c3_last", bus.out_last, 0);
        chk("b1_c3_addr", bus.mem_addr, 12'h012);
        next_cycle(); @(negedge clk);
        chk("b1_c4_data", bus.out_data, 32'hBEEF0011);
        chk("b1_c4_clken", bus.mem_clken, 1);
        chk("b1_c4_addr", bus.mem_addr, 12'h013);
        next_cycle(); @(negedge clk);
        chk("b1_c5_data", bus.out_data, 32'hBEEF0012);
        chk("b1_c5_clken", bus.mem_clken, 0);
        chk("b1_c5_addr_hold", bus.mem_addr, 12'h013);
        next_cycle(); @(negedge clk);
        chk("b1_c6_data", bus.out_data, 32'hBEEF0013);
        chk("b1_c6_last", bus.out_last, 1);
        next_cycle(); @(negedge clk);
        chk("b1_c7_valid", bus.out_valid, 0);
        chk("b1_c7_busy", bus.busy, 0);
        chk("b1_c7_cmd_ready", bus.cmd_ready, 1);
        next_cycle();

        // Bank crossing 0x3FF -> 0x400
        start_cmd(12'h3FE, 12'd4);
        collect(0, 50);
        exp_q = '{12'h3FE, 12'h3FF, 12'h400, 12'h401};
        check_burst("bank");
        chk("bank_bubble_cyc", iss_cyc[2], 4);
        chk("bank_next_cyc", iss_cyc[3], 5);

        // Wrap 0xFFF -> 0x000
        start_cmd(12'hFFE, 12'd3);
        collect(0, 50);
        exp_q = '{12'hFFE, 12'hFFF, 12'h000};
        check_burst("wrap");
        chk("wrap_bubble_cyc", iss_cyc[2], 4);

        // len=16 with out_ready 1-of-3
        start_cmd(12'h100, 12'd16);
        collect(1, 300);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(12'h100 + 12'(i));
        check_burst("slow");
        chk("slow_max_outstanding_le4", (max_out <= 4), 1);

        // Empty burst, then immediate next command
        bus.cmd_valid = 1'b1; bus.cmd_addr = 12'h020; bus.cmd_len = 12'd0;
        @(negedge clk);
        chk("len0_accept", bus.cmd_ready, 1);
        next_cycle();
        bus.cmd_addr = 12'h021; bus.cmd_len = 12'd1;
        @(negedge clk);
        chk("len0_cmd_ready", bus.cmd_ready, 1);
        chk("len0_busy", bus.busy, 0);
        chk("len0_clken", bus.mem_clken, 0);
        chk("len0_valid", bus.out_valid, 0);
        next_cycle();
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("len1_busy", bus.busy, 1);
        chk("len1_clken", bus.mem_clken, 1);
        chk("len1_addr", bus.mem_addr, 12'h021);
        next_cycle();
        collect(0, 20);
        chk("len1_words", got_data.size(), 1);
        chk("len1_data", got_data[0], 32'hBEEF0021);
        chk("len1_last", got_last[0], 1);

        // Reset in the middle of a len=8 burst
        start_cmd(12'h200, 12'd8);
        next_cycle(); next_cycle(); next_cycle();
        chk("mid_valid_before_reset", bus.out_valid, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_clken", bus.mem_clken, 0);
        chk("mid_rst_addr", bus.mem_addr, 0);
        chk("mid_rst_data", bus.out_data, 0);
        chk("mid_rst_last", bus.out_last, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        start_cmd(12'h030, 12'd2);
        collect(0, 30);
        exp_q = '{12'h030, 12'h031};
        check_burst("post_rst");

`ifdef BRAM_READER_ABORT_EN
        // Abort after the third word
        begin
            int lasts;
            lasts = 0;
            start_cmd(12'h040, 12'd8);
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                if (bus.out_last) lasts++;
                next_cycle();
            end
            bus.out_ready = 1'b0;
            abort = 1'b1;
            @(negedge clk);
            chk("abort_valid_before", bus.out_valid, 1);
            next_cycle();
            abort = 1'b0;
            bus.out_ready = 1'b1;
            @(negedge clk);
            chk("abort_valid_after", bus.out_valid, 0);
            chk("abort_busy", bus.busy, 0);
            chk("abort_cmd_ready", bus.cmd_ready, 1);
            chk("abort_last", bus.out_last, 0);
            next_cycle(); @(negedge clk);
            chk("abort_valid_later", bus.out_valid, 0);
            chk("abort_clken_later", bus.mem_clken, 0);
            chk("abort_no_last_seen", lasts, 0);
            next_cycle();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
